// File: rtl/surf_cout_align_pkg.sv
// surf_cout_align_pkg
// Shared definitions for the SURF COUT receive-PHY training controller:
//   - state_e      : training sequencer states
//   - TAP_W        : IDELAY tap index width
//   - CNT_W        : width of the shared phase counter
//   - is_rotation  : true when a nibble is any of the four rotations of a pattern
package surf_cout_align_pkg;

    localparam int TAP_W             = 6;
    localparam int CNT_W             = 8;
    localparam int SERDES_RST_CYCLES = 4;
    localparam int LOCK_MATCHES      = 4;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_RST_SERDES  = 4'd1,
        ST_LOAD        = 4'd2,
        ST_SETTLE      = 4'd3,
        ST_CHECK       = 4'd4,
        ST_NEXT        = 4'd5,
        ST_EVAL        = 4'd6,
        ST_CENTER_LOAD = 4'd7,
        ST_SLIP_CHECK  = 4'd8,
        ST_SLIP_WAIT   = 4'd9,
        ST_LOCKED      = 4'd10,
        ST_FAIL        = 4'd11
    } state_e;

    // A tap is usable before bitslip alignment as long as the word is
    // some rotation of the training nibble; bitslip fixes the phase later.
    function automatic logic is_rotation(input logic [3:0] word, input logic [3:0] pattern);
        logic hit;
        hit = (word == pattern)
           || (word == {pattern[2:0], pattern[3]})
           || (word == {pattern[1:0], pattern[3:2]})
           || (word == {pattern[0],   pattern[3:1]});
        return hit;
    endfunction

endpackage

// File: rtl/surf_cout_eye_tracker.sv
// surf_cout_eye_tracker
// Tracks the current run of consecutive good IDELAY taps and remembers the
// longest run seen so far. The earliest run wins a tie (strict greater-than).
// A run still open at the last tap is simply closed; there is no wrap-around.
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   clear_i         synchronous clear of all run registers
//   tap_done_i      one-cycle strobe: the score for tap_i is final
//   tap_good_i      score of tap_i
//   tap_i           index of the tap just scored
//   best_start_o    first tap of the longest run
//   best_len_o      length of the longest run
module surf_cout_eye_tracker
    import surf_cout_align_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             tap_done_i,
    input  logic             tap_good_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic [TAP_W-1:0] best_start_o,
    output logic [TAP_W:0]   best_len_o
);

    logic [TAP_W-1:0] cur_start_q, cur_start_d;
    logic [TAP_W-1:0] best_start_q, best_start_d;
    logic [TAP_W:0]   cur_len_q, cur_len_d;
    logic [TAP_W:0]   best_len_q, best_len_d;

    // Next-state of the current and best run on each scored tap.
    always_comb begin
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (clear_i) begin
            cur_start_d  = {TAP_W{1'b0}};
            cur_len_d    = {(TAP_W+1){1'b0}};
            best_start_d = {TAP_W{1'b0}};
            best_len_d   = {(TAP_W+1){1'b0}};
        end else if (tap_done_i) begin
            if (tap_good_i) begin
                cur_len_d = cur_len_q + (TAP_W+1)'(1);
                if (cur_len_q == {(TAP_W+1){1'b0}}) begin
                    cur_start_d = tap_i;
                end else begin
                    cur_start_d = cur_start_q;
                end
            end else begin
                cur_len_d = {(TAP_W+1){1'b0}};
            end
            if (cur_len_d > best_len_q) begin
                best_len_d   = cur_len_d;
                best_start_d = cur_start_d;
            end else begin
                best_len_d   = best_len_q;
                best_start_d = best_start_q;
            end
        end else begin
            cur_len_d = cur_len_q;
        end
    end

    // Run registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_start_q  <= {TAP_W{1'b0}};
            cur_len_q    <= {(TAP_W+1){1'b0}};
            best_start_q <= {TAP_W{1'b0}};
            best_len_q   <= {(TAP_W+1){1'b0}};
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;

endmodule

// File: rtl/surf_cout_align.sv
// surf_cout_align
// Training controller for the SURF COUT receive PHY (IDELAYE2 + 4-bit
// ISERDESE2). On start_i it resets the ISERDES, sweeps every IDELAY tap
// scoring it against the training nibble, loads the centre of the longest
// good run, then bitslips until the word equals TRAIN_PATTERN.
// Optional build macro SURF_COUT_ALIGN_MONITOR_EN adds post-lock error
// monitoring (err_count_o, lock_lost_o).
// Ports:
//   sysclk_i, sysclk_rstn_i   sole clock, asynchronous active-low reset
//   start_i                   one-cycle start / restart request
//   cout_i                    PHY parallel word
//   idelay_current_i          PHY CNTVALUEOUT (readback only, unused here)
//   idelay_value_o/_load_o    tap value and load strobe to the IDELAY
//   iserdes_rst_o             ISERDES reset
//   iserdes_bitslip_o         one-cycle bitslip strobe
//   busy_o/locked_o/fail_o    status
//   eye_start_o/eye_width_o   chosen good-tap run
//   slip_count_o              bitslips issued
// All outputs are registered. Counted phases must not exceed 256 cycles.
module surf_cout_align
    import surf_cout_align_pkg::*;
#(
    parameter logic [3:0] TRAIN_PATTERN = 4'hA,
    parameter int         NUM_TAPS      = 32,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         CHECK_CYCLES  = 64,
    parameter int         MIN_EYE       = 4,
    parameter int         SLIP_WAIT     = 4,
    parameter int         MAX_SLIPS     = 8
) (
    input  logic        sysclk_i,
    input  logic        sysclk_rstn_i,
    input  logic        start_i,
    input  logic [3:0]  cout_i,
    input  logic [5:0]  idelay_current_i,
    output logic [5:0]  idelay_value_o,
    output logic        idelay_load_o,
    output logic        iserdes_rst_o,
    output logic        iserdes_bitslip_o,
    output logic        busy_o,
    output logic        locked_o,
    output logic        fail_o,
    output logic [5:0]  eye_start_o,
    output logic [6:0]  eye_width_o,
`ifdef SURF_COUT_ALIGN_MONITOR_EN
    output logic [15:0] err_count_o,
    output logic        lock_lost_o,
`endif
    output logic [3:0]  slip_count_o
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(SERDES_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLIP_LAST   = CNT_W'(SLIP_WAIT - 1);
    localparam logic [CNT_W-1:0] MATCH_LAST  = CNT_W'(LOCK_MATCHES - 1);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);
    localparam logic [TAP_W:0]   MIN_EYE_LEN = (TAP_W+1)'(MIN_EYE);
    localparam logic [3:0]       SLIP_LIMIT  = 4'(MAX_SLIPS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [3:0]       slip_q, slip_d;
    logic [3:0]       first_q, first_d;
    logic             good_q, good_d;
    logic             centering_q, centering_d;
    logic [TAP_W-1:0] eye_start_q, eye_start_d;
    logic [TAP_W:0]   eye_width_q, eye_width_d;
    logic [TAP_W-1:0] value_q, value_d;
    logic             load_q, load_d;
    logic             srst_q, srst_d;
    logic             bitslip_q, bitslip_d;
    logic             busy_q, busy_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;

    logic             sample_ok_s;
    logic [TAP_W-1:0] best_start_s;
    logic [TAP_W:0]   best_len_s;
    logic [TAP_W-1:0] center_s;
    logic             unused_idelay_current_s;

`ifdef SURF_COUT_ALIGN_MONITOR_EN
    logic [15:0] err_count_q, err_count_d;
    logic [3:0]  miss_run_q, miss_run_d;
    logic        lock_lost_q, lock_lost_d;
`endif

    // CNTVALUEOUT is exposed to the register block elsewhere.
    assign unused_idelay_current_s = ^idelay_current_i;

    // First sample of a window only has to be a rotation; later ones must repeat it.
    assign sample_ok_s = (cnt_q == {CNT_W{1'b0}}) ? is_rotation(cout_i, TRAIN_PATTERN)
                                                  : (cout_i == first_q);

    // Floor centre of the best run; start + len/2 never exceeds the last tap.
    assign center_s = best_start_s + best_len_s[TAP_W:1];

    surf_cout_eye_tracker u_eye_tracker (
        .clk_i        (sysclk_i),
        .rst_ni       (sysclk_rstn_i),
        .clear_i      (start_i),
        .tap_done_i   (state_q == ST_NEXT),
        .tap_good_i   (good_q),
        .tap_i        (tap_q),
        .best_start_o (best_start_s),
        .best_len_o   (best_len_s)
    );

    // Training sequencer: next state and working registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tap_d       = tap_q;
        slip_d      = slip_q;
        first_d     = first_q;
        good_d      = good_q;
        centering_d = centering_q;
        eye_start_d = eye_start_q;
        eye_width_d = eye_width_q;
`ifdef SURF_COUT_ALIGN_MONITOR_EN
        err_count_d = err_count_q;
        miss_run_d  = miss_run_q;
        lock_lost_d = lock_lost_q;
`endif
        if (start_i) begin
            state_d     = ST_RST_SERDES;
            cnt_d       = {CNT_W{1'b0}};
            tap_d       = {TAP_W{1'b0}};
            slip_d      = 4'd0;
            first_d     = 4'd0;
            good_d      = 1'b0;
            centering_d = 1'b0;
            eye_start_d = {TAP_W{1'b0}};
            eye_width_d = {(TAP_W+1){1'b0}};
`ifdef SURF_COUT_ALIGN_MONITOR_EN
            err_count_d = 16'd0;
            miss_run_d  = 4'd0;
            lock_lost_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RST_SERDES: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_LOAD;
                        cnt_d   = {CNT_W{1'b0}};
                        tap_d   = {TAP_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    state_d = ST_SETTLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = centering_q ? ST_SLIP_CHECK : ST_CHECK;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    // The window always runs to completion so every tap costs the same time.
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        first_d = cout_i;
                        good_d  = sample_ok_s;
                    end else begin
                        first_d = first_q;
                        good_d  = good_q & sample_ok_s;
                    end
                    if (cnt_q == CHECK_LAST) begin
                        state_d = ST_NEXT;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (tap_q == LAST_TAP) begin
                        state_d = ST_EVAL;
                    end else begin
                        tap_d   = tap_q + TAP_W'(1);
                        state_d = ST_LOAD;
                    end
                end
                ST_EVAL: begin
                    if (best_len_s < MIN_EYE_LEN) begin
                        state_d = ST_FAIL;
                    end else begin
                        eye_start_d = best_start_s;
                        eye_width_d = best_len_s;
                        centering_d = 1'b1;
                        state_d     = ST_CENTER_LOAD;
                    end
                end
                ST_CENTER_LOAD: begin
                    state_d = ST_SETTLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
                ST_SLIP_CHECK: begin
                    // cnt_q counts consecutive exact matches here.
                    if (cout_i == TRAIN_PATTERN) begin
                        if (cnt_q == MATCH_LAST) begin
                            state_d = ST_LOCKED;
                            cnt_d   = {CNT_W{1'b0}};
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (slip_q == SLIP_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        slip_d  = slip_q + 4'd1;
                        state_d = ST_SLIP_WAIT;
                        cnt_d   = {CNT_W{1'b0}};
                    end
                end
                ST_SLIP_WAIT: begin
                    if (cnt_q == SLIP_LAST) begin
                        state_d = ST_SLIP_CHECK;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
`ifdef SURF_COUT_ALIGN_MONITOR_EN
                    if (cout_i != TRAIN_PATTERN) begin
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end else begin
                            err_count_d = err_count_q;
                        end
                        // This mismatch is the 16th in a row.
                        if (miss_run_q == 4'd15) begin
                            lock_lost_d = 1'b1;
                            state_d     = ST_FAIL;
                        end else begin
                            miss_run_d = miss_run_q + 4'd1;
                        end
                    end else begin
                        miss_run_d = 4'd0;
                    end
`else
                    state_d = ST_LOCKED;
`endif
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output next-values decoded from the next state so outputs track the state register.
    always_comb begin
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_LOCKED) && (state_d != ST_FAIL);
        srst_d    = (state_d == ST_RST_SERDES);
        load_d    = (state_d == ST_LOAD) || (state_d == ST_CENTER_LOAD);
        bitslip_d = (state_q == ST_SLIP_CHECK) && (state_d == ST_SLIP_WAIT);
        locked_d  = (state_d == ST_LOCKED);
        fail_d    = (state_d == ST_FAIL);
        // The tap value moves only together with a load strobe.
        if (state_d == ST_LOAD) begin
            value_d = tap_d;
        end else if (state_d == ST_CENTER_LOAD) begin
            value_d = center_s;
        end else begin
            value_d = value_q;
        end
    end

    // State, working and output registers.
    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            tap_q       <= {TAP_W{1'b0}};
            slip_q      <= 4'd0;
            first_q     <= 4'd0;
            good_q      <= 1'b0;
            centering_q <= 1'b0;
            eye_start_q <= {TAP_W{1'b0}};
            eye_width_q <= {(TAP_W+1){1'b0}};
            value_q     <= {TAP_W{1'b0}};
            load_q      <= 1'b0;
            srst_q      <= 1'b0;
            bitslip_q   <= 1'b0;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tap_q       <= tap_d;
            slip_q      <= slip_d;
            first_q     <= first_d;
            good_q      <= good_d;
            centering_q <= centering_d;
            eye_start_q <= eye_start_d;
            eye_width_q <= eye_width_d;
            value_q     <= value_d;
            load_q      <= load_d;
            srst_q      <= srst_d;
            bitslip_q   <= bitslip_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
        end
    end

`ifdef SURF_COUT_ALIGN_MONITOR_EN
    // Post-lock error monitor registers.
    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            err_count_q <= 16'd0;
            miss_run_q  <= 4'd0;
            lock_lost_q <= 1'b0;
        end else begin
            err_count_q <= err_count_d;
            miss_run_q  <= miss_run_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign err_count_o = err_count_q;
    assign lock_lost_o = lock_lost_q;
`endif

    assign idelay_value_o    = value_q;
    assign idelay_load_o     = load_q;
    assign iserdes_rst_o     = srst_q;
    assign iserdes_bitslip_o = bitslip_q;
    assign busy_o            = busy_q;
    assign locked_o          = locked_q;
    assign fail_o            = fail_q;
    assign eye_start_o       = eye_start_q;
    assign eye_width_o       = eye_width_q;
    assign slip_count_o      = slip_q;

endmodule
